// File: rtl/instruction_decode_queue_pkg.sv
// Shared decode types: IFD/IX payloads, opcodes, operation enums and queue entry.
// Used by instruction_decoder and instruction_decode_queue (DECODE_ILLEGAL_TRAP_EN aware).
package defines;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // CSRs that address the data cache and therefore execute in the LSU
    localparam logic [11:0] CSR_REG_DCACHE_FLUSH = 12'h7C0;
    localparam logic [11:0] CSR_REG_DCACHE_INV   = 12'h7C1;

    // Low three bits follow funct3; bit 3 selects the funct7[5] alternate
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,  ALU_SLL   = 4'd1,  ALU_SLT  = 4'd2,  ALU_SLTU = 4'd3,
        ALU_XOR   = 4'd4,  ALU_SRL   = 4'd5,  ALU_OR   = 4'd6,  ALU_AND  = 4'd7,
        ALU_SUB   = 4'd8,  ALU_LUI   = 4'd9,  ALU_AUIPC = 4'd10, ALU_JAL = 4'd11,
        ALU_JALR  = 4'd12, ALU_SRA   = 4'd13, ALU_BR   = 4'd14, ALU_CSR  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {MUL_MUL, MUL_MULH, MUL_MULHSU, MUL_MULHU} mul_op_e;
    typedef enum logic [1:0] {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU} div_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
    } imm_type_e;

    typedef enum logic [3:0] {
        EXE_PIPE_INVALID = 4'b0000,
        EXE_PIPE_ALU     = 4'b0001,
        EXE_PIPE_MUL     = 4'b0010,
        EXE_PIPE_DIV     = 4'b0100,
        EXE_PIPE_LSU     = 4'b1000
    } exe_pipe_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_inc;
    } ifd_id_inf_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_inc;
        logic [4:0]      a1;
        logic [4:0]      a2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm_ext;
        imm_type_e       imm_type;
        exe_pipe_e       exe_pipe;
        alu_op_e         alu_op;
        mul_op_e         mul_op;
        div_op_e         div_op;
        logic [2:0]      funct3;
        logic            register_write;
    } id_ix_inf_t;

    typedef struct packed {
        id_ix_inf_t inf;
        logic       illegal;
    } id_queue_entry_t;

    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        return alu_op_e'({alt && (f3 == 3'b000 || f3 == 3'b101), f3});
    endfunction

endpackage

// File: rtl/instruction_decode_queue_decoder.sv
// Combinational RV32IM decoder; pc/pc_inc are left zero for the queue to fill.
// DECODE_ILLEGAL_TRAP_EN: report unrecognised encodings through the illegal bit.
module instruction_decoder
    import defines::*;
(
    input  logic [XLEN-1:0] instr,
    output id_queue_entry_t entry
);

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_sh;
    logic            w_bad;
    logic            w_has_rd;
    exe_pipe_e       w_pipe;

    assign w_opc    = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u  = {instr[31:12], 12'b0};
    assign w_imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign w_imm_sh = {27'b0, instr[24:20]};

    always_comb begin
        entry    = '0;
        w_bad    = 1'b0;
        w_has_rd = 1'b0;
        w_pipe   = EXE_PIPE_ALU;
        entry.inf.funct3 = w_f3;
        case (w_opc)
            OPC_LUI, OPC_AUIPC: begin
                w_has_rd = 1'b1;
                entry.inf.rd       = instr[11:7];
                entry.inf.imm_type = IMM_U;
                entry.inf.imm_ext  = w_imm_u;
                entry.inf.alu_op   = (w_opc == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
            end
            OPC_JAL: begin
                w_has_rd = 1'b1;
                entry.inf.rd       = instr[11:7];
                entry.inf.imm_type = IMM_J;
                entry.inf.imm_ext  = w_imm_j;
                entry.inf.alu_op   = ALU_JAL;
            end
            OPC_JALR, OPC_LOAD, OPC_SYSTEM: begin
                w_has_rd = 1'b1;
                entry.inf.a1       = instr[19:15];
                entry.inf.rd       = instr[11:7];
                entry.inf.imm_type = IMM_I;
                entry.inf.imm_ext  = w_imm_i;
                entry.inf.alu_op   = (w_opc == OPC_JALR) ? ALU_JALR :
                                     (w_opc == OPC_SYSTEM) ? ALU_CSR : ALU_ADD;
                if (w_opc == OPC_LOAD ||
                    (w_opc == OPC_SYSTEM && (instr[31:20] == CSR_REG_DCACHE_FLUSH ||
                                             instr[31:20] == CSR_REG_DCACHE_INV)))
                    w_pipe = EXE_PIPE_LSU;
            end
            OPC_BRANCH, OPC_STORE: begin
                entry.inf.a1       = instr[19:15];
                entry.inf.a2       = instr[24:20];
                entry.inf.imm_type = (w_opc == OPC_BRANCH) ? IMM_B : IMM_S;
                entry.inf.imm_ext  = (w_opc == OPC_BRANCH) ? w_imm_b : w_imm_s;
                entry.inf.alu_op   = (w_opc == OPC_BRANCH) ? ALU_BR : ALU_ADD;
                if (w_opc == OPC_STORE)
                    w_pipe = EXE_PIPE_LSU;
            end
            OPC_OP_IMM: begin
                w_has_rd = 1'b1;
                entry.inf.a1 = instr[19:15];
                entry.inf.rd = instr[11:7];
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    entry.inf.imm_type = IMM_SH;
                    entry.inf.imm_ext  = w_imm_sh;
                    entry.inf.alu_op   = alu_from_f3(w_f3, instr[30]);
                end else begin
                    entry.inf.imm_type = IMM_I;
                    entry.inf.imm_ext  = w_imm_i;
                    entry.inf.alu_op   = alu_from_f3(w_f3, 1'b0);
                end
            end
            OPC_OP: begin
                w_has_rd = 1'b1;
                entry.inf.a1 = instr[19:15];
                entry.inf.a2 = instr[24:20];
                entry.inf.rd = instr[11:7];
                if (w_f7 == 7'h01) begin
                    w_pipe = w_f3[2] ? EXE_PIPE_DIV : EXE_PIPE_MUL;
                    entry.inf.mul_op = mul_op_e'(w_f3[1:0]);
                    entry.inf.div_op = div_op_e'(w_f3[1:0]);
                end else if (w_f7 == 7'h00) begin
                    entry.inf.alu_op = alu_from_f3(w_f3, 1'b0);
                end else if (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    entry.inf.alu_op = alu_from_f3(w_f3, 1'b1);
                end else begin
                    w_bad = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // fence.i runs in the ALU; a plain fence needs no execution unit
                if (w_f3 == 3'b000)
                    w_pipe = EXE_PIPE_INVALID;
                else if (w_f3 != 3'b001)
                    w_bad = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase

        if (w_bad)
            w_pipe = EXE_PIPE_INVALID;
        entry.inf.exe_pipe       = w_pipe;
        entry.inf.register_write = w_has_rd && (entry.inf.rd != 5'd0) &&
                                   (w_pipe != EXE_PIPE_INVALID);
`ifdef DECODE_ILLEGAL_TRAP_EN
        entry.illegal = w_bad;
`else
        entry.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/instruction_decode_queue.sv
// Decode stage: decodes one instruction per cycle into a DEPTH-entry FIFO toward IX.
// DECODE_ILLEGAL_TRAP_EN: store a per-entry illegal bit and expose it on id_illegal.
module instruction_decode_queue
    import defines::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_do_branch,
    input  logic             ifd_valid,
    input  ifd_id_inf_t      ifd_id_inf,
    output logic             ifd_ready,
    output logic             id_valid,
    output id_ix_inf_t       id_ix_inf,
    input  logic             ix_ready,
    output logic             id_illegal,
    output logic [CNT_W-1:0] queue_count
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

    id_queue_entry_t  w_dec;
    id_ix_inf_t       w_wr_inf;
    logic             w_enq;
    logic             w_deq;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    id_ix_inf_t       r_mem [QUEUE_DEPTH];

    instruction_decoder u_decoder (
        .instr (ifd_id_inf.instr),
        .entry (w_dec)
    );

    always_comb begin
        w_wr_inf        = w_dec.inf;
        w_wr_inf.pc     = ifd_id_inf.pc;
        w_wr_inf.pc_inc = ifd_id_inf.pc_inc;
    end

    assign ifd_ready   = (r_count != CNT_W'(QUEUE_DEPTH));
    assign id_valid    = (r_count != CNT_W'(0));
    assign w_enq       = ifd_valid && ifd_ready;
    assign w_deq       = id_valid && ix_ready;
    assign queue_count = r_count;
    assign id_ix_inf   = r_mem[r_rd_ptr];

    // Flush rewinds pointers and count only; stale entry contents are harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++)
                r_mem[i] <= '0;
        end else if (wb_do_branch) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= w_wr_inf;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_enq && !w_deq)
                r_count <= r_count + CNT_W'(1);
            else if (!w_enq && w_deq)
                r_count <= r_count - CNT_W'(1);
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic r_ill [QUEUE_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++)
                r_ill[i] <= 1'b0;
        end else if (!wb_do_branch && w_enq) begin
            r_ill[r_wr_ptr] <= w_dec.illegal;
        end
    end

    assign id_illegal = r_ill[r_rd_ptr];
`else
    logic w_unused_illegal;
    assign w_unused_illegal = w_dec.illegal;
    assign id_illegal       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Directed self-checking bench for instruction_decode_queue (QUEUE_DEPTH=4).
// Follows DECODE_ILLEGAL_TRAP_EN for the expected id_illegal value.
module tb_instruction_decode_queue;
    import defines::*;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_do_branch;
    logic        ifd_valid;
    ifd_id_inf_t ifd_id_inf;
    logic        ifd_ready;
    logic        id_valid;
    id_ix_inf_t  id_ix_inf;
    logic        ix_ready;
    logic        id_illegal;
    logic [2:0]  queue_count;

    int n_checks = 0;
    int n_errors = 0;

    instruction_decode_queue #(.QUEUE_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_do_branch (wb_do_branch),
        .ifd_valid    (ifd_valid),
        .ifd_id_inf   (ifd_id_inf),
        .ifd_ready    (ifd_ready),
        .id_valid     (id_valid),
        .id_ix_inf    (id_ix_inf),
        .ix_ready     (ix_ready),
        .id_illegal   (id_illegal),
        .queue_count  (queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ifd(input logic [31:0] instr, input logic [31:0] pc);
        ifd_id_inf.instr  = instr;
        ifd_id_inf.pc     = pc;
        ifd_id_inf.pc_inc = pc + 32'd4;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        set_ifd(instr, pc);
        ifd_valid = 1'b1;
        step;
        ifd_valid = 1'b0;
    endtask

    // Enqueue one instruction into an empty queue, check the decoded head, then pop it
    task automatic dec_check(input string tag, input logic [31:0] instr, input exe_pipe_e pipe,
                             input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                             input logic [31:0] imm, input logic rw, input logic ill);
        ix_ready = 1'b0;
        push(instr, 32'h40);
        chk({tag, ".valid"}, 32'(id_valid), 32'd1);
        chk({tag, ".pc"},    id_ix_inf.pc, 32'h40);
        chk({tag, ".pipe"},  32'(id_ix_inf.exe_pipe), 32'(pipe));
        chk({tag, ".a1"},    32'(id_ix_inf.a1), 32'(a1));
        chk({tag, ".a2"},    32'(id_ix_inf.a2), 32'(a2));
        chk({tag, ".rd"},    32'(id_ix_inf.rd), 32'(rd));
        chk({tag, ".imm"},   id_ix_inf.imm_ext, imm);
        chk({tag, ".rw"},    32'(id_ix_inf.register_write), 32'(rw));
        chk({tag, ".ill"},   32'(id_illegal), 32'(ill));
        ix_ready = 1'b1;
        step;
        ix_ready = 1'b0;
        chk({tag, ".drain"}, 32'(queue_count), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        wb_do_branch = 1'b0;
        ifd_valid    = 1'b0;
        ix_ready     = 1'b0;
        ifd_id_inf   = '0;
        #2;
        chk("rst.valid", 32'(id_valid), 32'd0);
        chk("rst.ready", 32'(ifd_ready), 32'd1);
        chk("rst.count", 32'(queue_count), 32'd0);
        chk("rst.ill",   32'(id_illegal), 32'd0);
        chk("rst.pc",    id_ix_inf.pc, 32'd0);
        chk("rst.imm",   id_ix_inf.imm_ext, 32'd0);
        step;
        step;
        rst = 1'b0;
        step;

        // Decode vectors
        dec_check("addi",    32'h00510093, EXE_PIPE_ALU,     5'd2, 5'd0, 5'd1, 32'd5,        1'b1, 1'b0);
        dec_check("mul",     32'h022081B3, EXE_PIPE_MUL,     5'd1, 5'd2, 5'd3, 32'd0,        1'b1, 1'b0);
        dec_check("nop",     32'h00000013, EXE_PIPE_ALU,     5'd0, 5'd0, 5'd0, 32'd0,        1'b0, 1'b0);
        dec_check("div",     32'h027342B3, EXE_PIPE_DIV,     5'd6, 5'd7, 5'd5, 32'd0,        1'b1, 1'b0);
        dec_check("lw",      32'h0080A203, EXE_PIPE_LSU,     5'd1, 5'd0, 5'd4, 32'd8,        1'b1, 1'b0);
        dec_check("sw",      32'hFE21AE23, EXE_PIPE_LSU,     5'd3, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0);
        dec_check("lui",     32'h123452B7, EXE_PIPE_ALU,     5'd0, 5'd0, 5'd5, 32'h12345000, 1'b1, 1'b0);
        dec_check("beq",     32'h00208463, EXE_PIPE_ALU,     5'd1, 5'd2, 5'd0, 32'd8,        1'b0, 1'b0);
        dec_check("jal",     32'h010000EF, EXE_PIPE_ALU,     5'd0, 5'd0, 5'd1, 32'd16,       1'b1, 1'b0);
        dec_check("srai",    32'h40315093, EXE_PIPE_ALU,     5'd2, 5'd0, 5'd1, 32'd3,        1'b1, 1'b0);
        dec_check("fence",   32'h0FF0000F, EXE_PIPE_INVALID, 5'd0, 5'd0, 5'd0, 32'd0,        1'b0, 1'b0);
        dec_check("illegal", 32'hFFFFFFFF, EXE_PIPE_INVALID, 5'd0, 5'd0, 5'd0, 32'd0,        1'b0, ILL_EXP);

        // Fill to full with IX stalled, then drain in order
        ix_ready  = 1'b0;
        ifd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ifd(NOP, 32'(i * 4));
            step;
        end
        chk("fill.count", 32'(queue_count), 32'd4);
        chk("fill.ready", 32'(ifd_ready), 32'd0);
        set_ifd(NOP, 32'h10);
        step;
        chk("fill.held_count", 32'(queue_count), 32'd4);
        chk("fill.stable_pc",  id_ix_inf.pc, 32'h0);
        ix_ready = 1'b1;
        step;
        chk("fill.pop0_count", 32'(queue_count), 32'd3);
        chk("fill.pop0_head",  id_ix_inf.pc, 32'h4);
        chk("fill.pop0_ready", 32'(ifd_ready), 32'd1);
        step;
        chk("fill.pop1_count", 32'(queue_count), 32'd3);
        chk("fill.pop1_head",  id_ix_inf.pc, 32'h8);
        ifd_valid = 1'b0;
        step;
        chk("fill.pop2_head",  id_ix_inf.pc, 32'hC);
        step;
        chk("fill.pop3_head",  id_ix_inf.pc, 32'h10);
        chk("fill.pop3_count", 32'(queue_count), 32'd1);
        step;
        chk("fill.empty",      32'(id_valid), 32'd0);
        ix_ready = 1'b0;

        // Concurrent enqueue/dequeue at occupancy 2 across pointer wrap
        push(NOP, 32'h100);
        push(NOP, 32'h104);
        ix_ready  = 1'b1;
        ifd_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("conc.head",  id_ix_inf.pc, 32'h100 + 32'(k * 4));
            chk("conc.count", 32'(queue_count), 32'd2);
            set_ifd(NOP, 32'h108 + 32'(k * 4));
            step;
        end
        ifd_valid = 1'b0;
        chk("conc.last_head", id_ix_inf.pc, 32'h128);
        step;
        step;
        chk("conc.drained", 32'(queue_count), 32'd0);
        ix_ready = 1'b0;

        // Flush with a same-cycle enqueue and dequeue
        push(NOP, 32'h200);
        push(NOP, 32'h204);
        push(NOP, 32'h208);
        chk("flush.pre_count", 32'(queue_count), 32'd3);
        set_ifd(NOP, 32'h20C);
        ifd_valid    = 1'b1;
        ix_ready     = 1'b1;
        wb_do_branch = 1'b1;
        step;
        wb_do_branch = 1'b0;
        ifd_valid    = 1'b0;
        ix_ready     = 1'b0;
        chk("flush.count", 32'(queue_count), 32'd0);
        chk("flush.valid", 32'(id_valid), 32'd0);
        chk("flush.ready", 32'(ifd_ready), 32'd1);
        push(NOP, 32'h300);
        chk("flush.next_head",  id_ix_inf.pc, 32'h300);
        chk("flush.next_count", 32'(queue_count), 32'd1);
        ix_ready = 1'b1;
        step;
        ix_ready = 1'b0;

        // Asynchronous reset mid-cycle with two entries queued
        push(32'hFFFFFFFF, 32'h400);
        push(NOP, 32'h404);
        chk("mrst.pre_count", 32'(queue_count), 32'd2);
        chk("mrst.pre_ill",   32'(id_illegal), 32'(ILL_EXP));
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.valid", 32'(id_valid), 32'd0);
        chk("mrst.count", 32'(queue_count), 32'd0);
        chk("mrst.ready", 32'(ifd_ready), 32'd1);
        chk("mrst.ill",   32'(id_illegal), 32'd0);
        chk("mrst.pc",    id_ix_inf.pc, 32'd0);
        step;
        rst = 1'b0;
        step;
        chk("mrst.post_count", 32'(queue_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode_queue.md
# instruction_decode_queue

Next-generation decode stage between instruction fetch-data (IFD) and issue (IX). It decodes one RV32IM instruction per cycle into an `id_ix_inf_t` record and buffers decoded records in a parametrised-depth FIFO with valid/ready handshakes on both sides. Compared with the previous decode stage, it adds real backpressure: IX can stall without losing instructions, and IFD is throttled only when the queue is full. A branch redirect from WB flushes the whole queue.

## Interface
Parameters:
- `QUEUE_DEPTH`, default 4: number of decoded entries. Must be a power of two and at least 2.
- `CNT_W`, default `$clog2(QUEUE_DEPTH+1)`: width of the occupancy count. Derived; do not override.

Ports:
- `clk`  in  1  Single clock domain.
- `rst`  in  1  Reset. Asynchronous, active-high.
- `wb_do_branch`  in  1  Redirect from WB. Flushes the queue.
- `ifd_valid`  in  1  IFD presents an instruction.
- `ifd_id_inf`  in  `ifd_id_inf_t`  Carries `instr`, `pc` and `pc_inc`.
- `ifd_ready`  out  1  Queue can accept an instruction this cycle.
- `id_valid`  out  1  Head entry is valid.
- `id_ix_inf`  out  `id_ix_inf_t`  Decoded head entry.
- `ix_ready`  in  1  IX consumes the head entry this cycle.
- `id_illegal`  out  1  Head entry is an illegal instruction. Qualified by `id_valid`.
- `queue_count`  out  `CNT_W`  Current occupancy, 0..`QUEUE_DEPTH`.

## Operation
Decode:
- Combinational, RV32IM base set.
- Field extraction:
  - `a1`/`a2`/`rd` come from `instr[19:15]`/`[24:20]`/`[11:7]`.
  - Operands are zeroed where the format has no such operand: stores and branches have no `rd`; LUI/AUIPC/JAL have no `a1`; I-type instructions have no `a2`.
- Immediates: I/S/B/J are sign-extended; SH is the zero-extended 5-bit shamt; U is `instr[31:12]` followed by 12 zero bits.
- `exe_pipe` is one-hot:
  - OP with `funct7[0]`=1: MUL when `funct3[2]`=0, DIV when `funct3[2]`=1.
  - Loads, stores and D$ CSR ops: LSU.
  - Everything else (including `fence.i`): ALU.
  - Plain FENCE and unrecognised encodings: `EXE_PIPE_INVALID`.
- `register_write` is forced to 0 when `rd`=0.

Queue:
- Enqueue happens when `ifd_valid && ifd_ready`. The decoded record plus its illegal bit is written at `wr_ptr`.
- Dequeue happens when `id_valid && ix_ready`.
- `ifd_ready = (queue_count != QUEUE_DEPTH)`. It depends only on registered state; there is no combinational path from `ix_ready`.
- No empty bypass: an accepted instruction becomes visible the cycle after the edge that captured it.
- Simultaneous enqueue and dequeue: the count is unchanged and both pointers advance.
- When full, `ifd_ready`=0, so enqueue cannot occur even if a dequeue happens in the same cycle.
- Pointers are `$clog2(QUEUE_DEPTH)` bits wide and wrap naturally.
- `id_ix_inf` and `id_illegal` are read from the entry at `rd_ptr`.

Flush:
- When `wb_do_branch`=1 at an edge, `queue_count`, `wr_ptr` and `rd_ptr` all go to 0.
- Any same-cycle enqueue or dequeue is discarded.
- Entry contents are not cleared.

## Timing
- Reset (asynchronous, immediate): `id_valid`=0, `ifd_ready`=1, `queue_count`=0, `id_illegal`=0, `id_ix_inf`='0. Every storage entry resets to '0.
- Reset asserted mid-operation: all queued entries are lost at once; no handshake completes in that cycle.
- Latency from IFD accept to `id_valid`: 1 cycle.
- Sustained throughput: 1 instruction per cycle in and out.
- Priority at an edge: `rst` > `wb_do_branch` > enqueue/dequeue.
- `id_ix_inf` stays stable while `id_valid && !ix_ready`.

## Configuration
Macro: `DECODE_ILLEGAL_TRAP_EN`.

Defined:
- An instruction is illegal if any of the following holds:
  - its opcode is outside the implemented set;
  - it is OP with `funct7` not in {0x00, 0x20, 0x01};
  - it is OP with `funct7`=0x20 and `funct3` not in {000, 101};
  - it is FENCE with `funct3` not in {000, 001};
  - its `instr[1:0]` != 2'b11.
- Illegal instructions are enqueued with `exe_pipe`=`EXE_PIPE_INVALID`, `register_write`=0, and illegal bit =1.
- `id_illegal` mirrors the head entry's illegal bit.

Not defined:
- `id_illegal` is tied to 0.
- No illegal bit is stored.
- Unrecognised encodings are enqueued as no-ops (`EXE_PIPE_INVALID`, `register_write`=0).

## Structure
- Shared package `defines`:
  - existing `ifd_id_inf_t`, `id_ix_inf_t`, opcode, `alu_op_e`/`mul_op_e`/`div_op_e`, `imm_type_e`, `exe_pipe_e` and `CSR_REG_*` constants;
  - new `id_queue_entry_t` = {`id_ix_inf_t` `inf`; logic `illegal`}.
- Sub-module `instruction_decoder`: purely combinational; `instr` in, `id_queue_entry_t` minus `pc`/`pc_inc` out.
- The queue storage, pointers and count live in `instruction_decode_queue`.

## Test plan
- Decode: `addi x1,x2,5` (0x00510093) -> head has `exe_pipe`=ALU, `a1`=2, `a2`=0, `rd`=1, `imm_ext`=5, `register_write`=1, one cycle after accept.
- Decode: `mul x3,x1,x2` (0x022081B3) -> `exe_pipe`=MUL. `addi x0,x0,0` -> `register_write`=0.
- Fill: `QUEUE_DEPTH`=4, `ix_ready`=0, 5 back-to-back valid instructions -> `ifd_ready` drops after the 4th accept, `queue_count`=4, 5th held. Then `ix_ready`=1 -> pops in order (PCs 0x0,0x4,0x8,0xC), 5th accepted after the first pop.
- Concurrent traffic: `queue_count`=2 with enqueue and dequeue every cycle for 10 cycles -> `queue_count` stays 2, PC order preserved across pointer wrap.
- Flush: `queue_count`=3 and `wb_do_branch`=1 together with `ifd_valid`=1 -> next cycle `queue_count`=0, `id_valid`=0, flush-cycle instruction never appears.
- Illegal/reset: with `DECODE_ILLEGAL_TRAP_EN`, enqueue 0xFFFFFFFF -> `id_illegal`=1, `register_write`=0, `exe_pipe`=INVALID. Then assert `rst` mid-cycle with 2 entries queued -> `id_valid`=0 and `queue_count`=0 immediately, before the next edge.
